// File: rtl/i2c_lcd_sequencer_pkg.sv
// Shared types and constants for the PCF8574/HD44780 I2C LCD sequencer.
// Holds the op and state encodings, PCF8574 bit positions, the power-up ROM and delay constants.
// Used by i2c_lcd_sequencer and us_delay_timer.
package lcd_i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_STOP  = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_PWRUP_WAIT,
    ST_INIT_LOAD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_IDLE,
    ST_ERR_STOP
  } state_e;

  // PCF8574 output byte layout: {D7..D4, BL, EN, RW, RS}
  localparam int PCF_RS = 0;
  localparam int PCF_RW = 1;
  localparam int PCF_EN = 2;
  localparam int PCF_BL = 3;

  localparam logic [15:0] PWRUP_US = 16'd50000;
  localparam logic [15:0] SLOW_US  = 16'd2000;  // clear / home instructions
  localparam logic [15:0] FAST_US  = 16'd50;

  // Frame op index: 0 START, 1 ADDR, 2..5 data bytes, 6 STOP
  localparam logic [2:0] IDX_START = 3'd0;
  localparam logic [2:0] IDX_NIB_LAST = 3'd3;
  localparam logic [2:0] IDX_STOP  = 3'd6;
  localparam logic [2:0] INIT_LAST = 3'd7;

  typedef struct packed {
    logic        is_byte;
    logic [7:0]  val;
    logic [15:0] us;
  } init_step_t;

  function automatic init_step_t init_rom(input logic [2:0] step);
    init_step_t s;
    s = '{is_byte: 1'b0, val: 8'h03, us: 16'd4100};
    case (step)
      3'd0: s = '{is_byte: 1'b0, val: 8'h03, us: 16'd4100};
      3'd1: s = '{is_byte: 1'b0, val: 8'h03, us: 16'd100};
      3'd2: s = '{is_byte: 1'b0, val: 8'h03, us: 16'd100};
      3'd3: s = '{is_byte: 1'b0, val: 8'h02, us: 16'd100};
      3'd4: s = '{is_byte: 1'b1, val: 8'h28, us: FAST_US};
      3'd5: s = '{is_byte: 1'b1, val: 8'h0C, us: FAST_US};
      3'd6: s = '{is_byte: 1'b1, val: 8'h01, us: SLOW_US};
      3'd7: s = '{is_byte: 1'b1, val: 8'h06, us: FAST_US};
      default: s = '{is_byte: 1'b0, val: 8'h03, us: 16'd4100};
    endcase
    return s;
  endfunction

  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                          input logic en, input logic rs);
    logic [7:0] b;
    b = '0;
    b[7:4]   = nib;
    b[PCF_BL] = bl;
    b[PCF_EN] = en;
    b[PCF_RW] = 1'b0;
    b[PCF_RS] = rs;
    return b;
  endfunction

endpackage

// File: rtl/i2c_lcd_sequencer_us_delay_timer.sv
// Microsecond delay timer: a CLK_HZ/1e6 prescaler feeding a 16-bit microsecond down-counter.
// Latency: o_expired is high in the last cycle of an i_us-microsecond interval started by i_load.
// No backpressure; i_load restarts the interval at any time.
// Ports: clk, rst (async active-low), i_load, i_us[15:0], o_expired.
module us_delay_timer
  import lcd_i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_us,
  output logic        o_expired
);

  localparam int unsigned PRE    = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam logic [31:0] PRE_M1 = PRE - 1;

  logic [31:0] r_pre;
  logic [15:0] r_us;
  logic        r_run;
  logic        w_tick;

  assign w_tick    = r_run && (r_pre == '0);
  // A zero-length request expires on the first tick, like a one-microsecond one.
  assign o_expired = w_tick && (r_us <= 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_us  <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_pre <= PRE_M1;
      r_us  <= i_us;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_pre != '0) begin
        r_pre <= r_pre - 32'd1;
      end else begin
        r_pre <= PRE_M1;
        if (r_us <= 16'd1) r_run <= 1'b0;
        else               r_us  <= r_us - 16'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_lcd_sequencer.sv
// Expands LCD writes into PCF8574 I2C frames for a byte-level master and runs the HD44780 4-bit power-up.
// Latency: write accepted at edge k gives START on m_valid at k+1; next op one cycle after each m_done.
// Backpressure: m_valid/m_op/m_data held until m_ready; wr_ready only in IDLE after init.
// Ports: clk, rst (async active-low); user wr_valid/wr_ready/wr_rs/wr_data; status init_done/busy/err;
//        master m_valid/m_ready/m_op/m_data/m_done/m_nack.
module i2c_lcd_sequencer
  import lcd_i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter logic [6:0]  DEV_ADDR  = 7'h27,
  parameter logic        BACKLIGHT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic       err,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_op,
  output logic [7:0] m_data,
  input  logic       m_done,
  input  logic       m_nack
);

  state_e      r_state, w_state;
  logic [2:0]  r_step, w_step;
  logic [2:0]  r_idx, w_idx;
  logic        r_init, w_init;     // current frame belongs to the power-up sequence
  logic        r_nib, w_nib;       // nibble-only frame (early init steps)
  logic        r_rs, w_rs;
  logic [7:0]  r_byte, w_byte;
  logic [15:0] r_dly, w_dly;
  logic        r_abort, w_abort;   // the STOP in flight closes a NACKed frame
  logic        r_err, w_err;
  logic        r_done, w_done;
  logic        r_armed;            // power-up timer already loaded in this PWRUP_WAIT visit
  logic        w_tmr_load;
  logic [15:0] w_tmr_us;
  logic        w_expired;
  init_step_t  w_rom;
  op_e         w_op;
  logic [7:0]  w_dat;

  us_delay_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_us      (w_tmr_us),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_PWRUP_WAIT;
      r_step  <= '0;
      r_idx   <= '0;
      r_init  <= 1'b0;
      r_nib   <= 1'b0;
      r_rs    <= 1'b0;
      r_byte  <= '0;
      r_dly   <= '0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state;
      r_step  <= w_step;
      r_idx   <= w_idx;
      r_init  <= w_init;
      r_nib   <= w_nib;
      r_rs    <= w_rs;
      r_byte  <= w_byte;
      r_dly   <= w_dly;
      r_abort <= w_abort;
      r_err   <= w_err;
      r_done  <= w_done;
      r_armed <= (r_state == ST_PWRUP_WAIT);
    end
  end

  always_comb begin
    w_state    = r_state;
    w_step     = r_step;
    w_idx      = r_idx;
    w_init     = r_init;
    w_nib      = r_nib;
    w_rs       = r_rs;
    w_byte     = r_byte;
    w_dly      = r_dly;
    w_abort    = r_abort;
    w_err      = r_err;
    w_done     = r_done;
    w_tmr_load = 1'b0;
    w_tmr_us   = r_dly;
    w_rom      = init_rom(r_step);
    case (r_state)
      ST_PWRUP_WAIT: begin
        if (!r_armed) begin
          w_tmr_load = 1'b1;
          w_tmr_us   = PWRUP_US;
        end else if (w_expired) begin
          w_state = ST_INIT_LOAD;
          w_step  = '0;
          w_init  = 1'b1;
        end
      end
      ST_INIT_LOAD: begin
        w_nib   = !w_rom.is_byte;
        // Nibble steps sit in the high half so they share the hi-nibble ops.
        w_byte  = w_rom.is_byte ? w_rom.val : {w_rom.val[3:0], 4'h0};
        w_rs    = 1'b0;
        w_dly   = w_rom.us;
        w_idx   = IDX_START;
        w_abort = 1'b0;
        w_state = ST_ISSUE;
      end
      ST_IDLE: begin
        if (wr_valid && r_done) begin
          w_init  = 1'b0;
          w_nib   = 1'b0;
          w_rs    = wr_rs;
          w_byte  = wr_data;
          w_dly   = (!wr_rs && wr_data >= 8'h01 && wr_data <= 8'h03) ? SLOW_US : FAST_US;
          w_idx   = IDX_START;
          w_abort = 1'b0;
          w_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) w_state = ST_WAIT_DONE;
      end
      ST_ERR_STOP: begin
        if (m_ready) begin
          w_state = ST_WAIT_DONE;
          w_idx   = IDX_STOP;
          w_abort = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (m_done) begin
          if (r_idx == IDX_STOP) begin
            if (r_abort) begin
              w_abort = 1'b0;
              if (r_init) begin
                w_state = ST_PWRUP_WAIT;
                w_step  = '0;
              end else begin
                w_state = ST_IDLE;
              end
            end else begin
              w_tmr_load = 1'b1;
              w_tmr_us   = r_dly;
              w_state    = ST_DELAY;
              if (!r_init) w_err = 1'b0;
            end
          end else if (m_nack && r_idx != IDX_START) begin
            w_err   = 1'b1;
            w_state = ST_ERR_STOP;
          end else begin
            w_idx   = (r_nib && r_idx == IDX_NIB_LAST) ? IDX_STOP : r_idx + 3'd1;
            w_state = ST_ISSUE;
          end
        end
      end
      ST_DELAY: begin
        if (w_expired) begin
          if (!r_init) begin
            w_state = ST_IDLE;
          end else if (r_step == INIT_LAST) begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
            w_init  = 1'b0;
          end else begin
            w_step  = r_step + 3'd1;
            w_state = ST_INIT_LOAD;
          end
        end
      end
      default: w_state = ST_PWRUP_WAIT;
    endcase
  end

  always_comb begin
    w_op  = OP_STOP;
    w_dat = '0;
    case (r_idx)
      3'd0: w_op = OP_START;
      3'd1: begin w_op = OP_WRITE; w_dat = {DEV_ADDR, 1'b0}; end
      3'd2: begin w_op = OP_WRITE; w_dat = pcf_byte(r_byte[7:4], BACKLIGHT, 1'b1, r_rs); end
      3'd3: begin w_op = OP_WRITE; w_dat = pcf_byte(r_byte[7:4], BACKLIGHT, 1'b0, r_rs); end
      3'd4: begin w_op = OP_WRITE; w_dat = pcf_byte(r_byte[3:0], BACKLIGHT, 1'b1, r_rs); end
      3'd5: begin w_op = OP_WRITE; w_dat = pcf_byte(r_byte[3:0], BACKLIGHT, 1'b0, r_rs); end
      default: begin w_op = OP_STOP; w_dat = '0; end
    endcase
    m_valid = 1'b0;
    m_op    = OP_START;
    m_data  = '0;
    if (r_state == ST_ISSUE) begin
      m_valid = 1'b1;
      m_op    = w_op;
      m_data  = w_dat;
    end else if (r_state == ST_ERR_STOP) begin
      m_valid = 1'b1;
      m_op    = OP_STOP;
    end
  end

  assign wr_ready  = (r_state == ST_IDLE) && r_done;
  assign busy      = (r_state != ST_IDLE);
  assign init_done = r_done;
  assign err       = r_err;

endmodule
